// File: rtl/eip_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : eip_redirect_ctrl
// Brief    : Arbitrates architectural EIP updates between exception vectoring,
//            taken writeback control transfers and sequential decode advance.
//            An accepted redirect raises a valid/ready request to fetch,
//            flushes the pipeline and stalls decode through a drain window.
// Revision : 1.0 - initial release
// ============================================================================
module eip_redirect_ctrl #(
    parameter logic [31:0] RESET_EIP    = 32'h0000_FFF0,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r_V_wb,
    input  logic        r_wb_eip_change,
    input  logic        r_wb_cond_met,
    input  logic [31:0] r_wb_target,
    input  logic        r_wb_pr_size_over,
    input  logic        r_V_de,
    input  logic        w_not_stall_fe,
    input  logic [31:0] w_de_EIP_next,
    input  logic        exc_req,
    input  logic [31:0] exc_vector,
    input  logic        fe_redirect_ready,
    output logic [31:0] r_EIP,
    output logic        fe_redirect_valid,
    output logic [31:0] fe_redirect_addr,
    output logic        flush_pipe,
    output logic        stall_de,
    output logic        exc_ack
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REDIR = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] C_FLUSH = FLUSH_CYCLES[3:0];

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt,   w_cnt_nxt;
    logic [31:0] r_eip,   w_eip_nxt;
    logic [31:0] r_addr,  w_addr_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_flush, w_flush_nxt;
    logic        r_stall, w_stall_nxt;
    logic        r_ack,   w_ack_nxt;

    logic        w_wb_take;
    logic [31:0] w_wb_target_m;

    assign w_wb_take     = r_V_wb & r_wb_eip_change & r_wb_cond_met;
    // A 16-bit operand size wraps the branch target inside the low 64 KiB.
    assign w_wb_target_m = r_wb_pr_size_over ? {16'h0000, r_wb_target[15:0]}
                                             : r_wb_target;

    // Next-state and next-output selection; every output is registered below.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_eip_nxt   = r_eip;
        w_addr_nxt  = r_addr;
        w_valid_nxt = r_valid;
        w_flush_nxt = r_flush;
        w_stall_nxt = r_stall;
        w_ack_nxt   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (exc_req) begin
                    w_eip_nxt   = exc_vector;
                    w_addr_nxt  = exc_vector;
                    w_ack_nxt   = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_flush_nxt = 1'b1;
                    w_stall_nxt = 1'b1;
                    w_state_nxt = ST_REDIR;
                end else if (w_wb_take) begin
                    w_eip_nxt   = w_wb_target_m;
                    w_addr_nxt  = w_wb_target_m;
                    w_valid_nxt = 1'b1;
                    w_flush_nxt = 1'b1;
                    w_stall_nxt = 1'b1;
                    w_state_nxt = ST_REDIR;
                end else if (r_V_de & w_not_stall_fe) begin
                    w_eip_nxt = w_de_EIP_next;
                end
            end
            ST_REDIR: begin
                // Wrong-path writeback/decode activity is squashed here.
                if (r_valid & fe_redirect_ready) begin
                    w_valid_nxt = 1'b0;
                    if (C_FLUSH == 4'd0) begin
                        w_flush_nxt = 1'b0;
                        w_stall_nxt = 1'b0;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt   = C_FLUSH;
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_flush_nxt = 1'b0;
                    w_stall_nxt = 1'b0;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
            r_eip   <= RESET_EIP;
            r_addr  <= RESET_EIP;
            r_valid <= 1'b0;
            r_flush <= 1'b0;
            r_stall <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_eip   <= w_eip_nxt;
            r_addr  <= w_addr_nxt;
            r_valid <= w_valid_nxt;
            r_flush <= w_flush_nxt;
            r_stall <= w_stall_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    assign r_EIP             = r_eip;
    assign fe_redirect_valid = r_valid;
    assign fe_redirect_addr  = r_addr;
    assign flush_pipe        = r_flush;
    assign stall_de          = r_stall;
    assign exc_ack           = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_eip_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_eip_redirect_ctrl
// Brief    : Directed self-checking bench for eip_redirect_ctrl, with a
//            second instance built for a zero-length drain window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eip_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        r_V_wb;
    logic        r_wb_eip_change;
    logic        r_wb_cond_met;
    logic [31:0] r_wb_target;
    logic        r_wb_pr_size_over;
    logic        r_V_de;
    logic        w_not_stall_fe;
    logic [31:0] w_de_EIP_next;
    logic        exc_req;
    logic [31:0] exc_vector;
    logic        fe_redirect_ready;

    logic [31:0] w_eip,   w_eip0;
    logic        w_valid, w_valid0;
    logic [31:0] w_addr,  w_addr0;
    logic        w_flush, w_flush0;
    logic        w_stall, w_stall0;
    logic        w_ack,   w_ack0;

    int n_checks;
    int n_pass;

    eip_redirect_ctrl #(.RESET_EIP(32'h0000_FFF0), .FLUSH_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r_V_wb(r_V_wb), .r_wb_eip_change(r_wb_eip_change),
        .r_wb_cond_met(r_wb_cond_met), .r_wb_target(r_wb_target),
        .r_wb_pr_size_over(r_wb_pr_size_over),
        .r_V_de(r_V_de), .w_not_stall_fe(w_not_stall_fe),
        .w_de_EIP_next(w_de_EIP_next),
        .exc_req(exc_req), .exc_vector(exc_vector),
        .fe_redirect_ready(fe_redirect_ready),
        .r_EIP(w_eip), .fe_redirect_valid(w_valid),
        .fe_redirect_addr(w_addr), .flush_pipe(w_flush),
        .stall_de(w_stall), .exc_ack(w_ack)
    );

    eip_redirect_ctrl #(.RESET_EIP(32'h0000_FFF0), .FLUSH_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .r_V_wb(r_V_wb), .r_wb_eip_change(r_wb_eip_change),
        .r_wb_cond_met(r_wb_cond_met), .r_wb_target(r_wb_target),
        .r_wb_pr_size_over(r_wb_pr_size_over),
        .r_V_de(r_V_de), .w_not_stall_fe(w_not_stall_fe),
        .w_de_EIP_next(w_de_EIP_next),
        .exc_req(exc_req), .exc_vector(exc_vector),
        .fe_redirect_ready(fe_redirect_ready),
        .r_EIP(w_eip0), .fe_redirect_valid(w_valid0),
        .fe_redirect_addr(w_addr0), .flush_pipe(w_flush0),
        .stall_de(w_stall0), .exc_ack(w_ack0)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_idle();
        r_V_wb = 1'b0; r_wb_eip_change = 1'b0; r_wb_cond_met = 1'b0;
        r_wb_target = 32'h0; r_wb_pr_size_over = 1'b0;
    endtask

    task automatic wb_branch(input logic [31:0] tgt, input logic sz, input logic cond);
        r_V_wb = 1'b1; r_wb_eip_change = 1'b1; r_wb_cond_met = cond;
        r_wb_target = tgt; r_wb_pr_size_over = sz;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        wb_idle();
        r_V_de = 1'b0; w_not_stall_fe = 1'b1; w_de_EIP_next = 32'h0;
        exc_req = 1'b0; exc_vector = 32'h0; fe_redirect_ready = 1'b0;

        // Reset values.
        tick(); tick();
        chk("rst_eip",   w_eip,   32'h0000_FFF0);
        chk("rst_addr",  w_addr,  32'h0000_FFF0);
        chk("rst_valid", {31'b0, w_valid}, 32'd0);
        chk("rst_flush", {31'b0, w_flush}, 32'd0);
        chk("rst_stall", {31'b0, w_stall}, 32'd0);
        chk("rst_ack",   {31'b0, w_ack},   32'd0);
        rst_n = 1'b1;

        // Sequential decode advance.
        r_V_de = 1'b1; w_de_EIP_next = 32'h1000;
        tick(); chk("seq0", w_eip, 32'h1000);
        w_de_EIP_next = 32'h1003;
        tick(); chk("seq1", w_eip, 32'h1003);
        w_de_EIP_next = 32'h1007;
        tick(); chk("seq2", w_eip, 32'h1007);
        chk("seq_flush", {31'b0, w_flush}, 32'd0);

        // Taken branch, 16-bit masked target; decode traffic must be ignored.
        w_de_EIP_next = 32'h0000_AAAA;
        wb_branch(32'h1234_5678, 1'b1, 1'b1);
        tick();
        wb_idle();
        chk("br_eip",   w_eip,  32'h0000_5678);
        chk("br_addr",  w_addr, 32'h0000_5678);
        chk("br_v1",    {31'b0, w_valid}, 32'd1);
        chk("br_flush", {31'b0, w_flush}, 32'd1);
        chk("br_stall", {31'b0, w_stall}, 32'd1);
        chk("br_noack", {31'b0, w_ack},   32'd0);
        tick(); chk("br_v2", {31'b0, w_valid}, 32'd1);
        tick(); chk("br_v3", {31'b0, w_valid}, 32'd1);
        tick(); chk("br_v4", {31'b0, w_valid}, 32'd1);
        chk("br_hold_eip", w_eip, 32'h0000_5678);
        fe_redirect_ready = 1'b1;
        tick();
        fe_redirect_ready = 1'b0;
        chk("br_d1_valid", {31'b0, w_valid}, 32'd0);
        chk("br_d1_flush", {31'b0, w_flush}, 32'd1);
        chk("br_d1_stall", {31'b0, w_stall}, 32'd1);
        tick();
        chk("br_d2_flush", {31'b0, w_flush}, 32'd1);
        chk("br_d2_eip",   w_eip, 32'h0000_5678);
        tick();
        chk("br_run_flush", {31'b0, w_flush}, 32'd0);
        chk("br_run_stall", {31'b0, w_stall}, 32'd0);
        chk("br_run_eip",   w_eip, 32'h0000_5678);
        tick();
        chk("br_resume", w_eip, 32'h0000_AAAA);
        r_V_de = 1'b0;

        // Exception beats a simultaneous taken branch.
        exc_req = 1'b1; exc_vector = 32'h8000;
        wb_branch(32'h2000, 1'b0, 1'b1);
        tick();
        wb_idle();
        exc_req = 1'b0;
        chk("exc_eip",  w_eip,  32'h8000);
        chk("exc_addr", w_addr, 32'h8000);
        chk("exc_ack1", {31'b0, w_ack}, 32'd1);
        fe_redirect_ready = 1'b1;
        tick();
        fe_redirect_ready = 1'b0;
        chk("exc_ack0", {31'b0, w_ack}, 32'd0);
        chk("exc_eip2", w_eip, 32'h8000);
        tick(); tick();
        chk("exc_run_flush", {31'b0, w_flush}, 32'd0);
        chk("exc_no2000",    w_eip, 32'h8000);

        // Requests during DRAIN: branch and decode dropped, exception pending.
        wb_branch(32'h4000, 1'b0, 1'b1);
        tick();
        wb_idle();
        fe_redirect_ready = 1'b1;
        tick();
        fe_redirect_ready = 1'b0;
        wb_branch(32'h3000, 1'b0, 1'b1);
        r_V_de = 1'b1; w_de_EIP_next = 32'h0000_BBBB;
        exc_req = 1'b1; exc_vector = 32'h9000;
        tick();
        chk("dr_eip",   w_eip, 32'h4000);
        chk("dr_ack",   {31'b0, w_ack},   32'd0);
        chk("dr_flush", {31'b0, w_flush}, 32'd1);
        tick();
        chk("dr_exit_eip",   w_eip, 32'h4000);
        chk("dr_exit_ack",   {31'b0, w_ack},   32'd0);
        chk("dr_exit_flush", {31'b0, w_flush}, 32'd0);
        tick();
        chk("b2b_ack",   {31'b0, w_ack},   32'd1);
        chk("b2b_eip",   w_eip,  32'h9000);
        chk("b2b_addr",  w_addr, 32'h9000);
        chk("b2b_valid", {31'b0, w_valid}, 32'd1);
        exc_req = 1'b0; wb_idle(); r_V_de = 1'b0;
        fe_redirect_ready = 1'b1;
        tick();
        fe_redirect_ready = 1'b0;
        tick(); tick();
        chk("b2b_run", {31'b0, w_stall}, 32'd0);

        // Branch with condition not met: plain sequential update.
        wb_branch(32'h5555, 1'b0, 1'b0);
        r_V_de = 1'b1; w_de_EIP_next = 32'h2222;
        tick();
        wb_idle(); r_V_de = 1'b0;
        chk("nt_eip",   w_eip, 32'h2222);
        chk("nt_valid", {31'b0, w_valid}, 32'd0);
        chk("nt_flush", {31'b0, w_flush}, 32'd0);

        // Reset while in REDIR abandons the handshake.
        wb_branch(32'h6000, 1'b0, 1'b1);
        tick();
        wb_idle();
        chk("mr_valid", {31'b0, w_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_eip",   w_eip,  32'h0000_FFF0);
        chk("mr_addr",  w_addr, 32'h0000_FFF0);
        chk("mr_valid0", {31'b0, w_valid}, 32'd0);
        chk("mr_flush", {31'b0, w_flush}, 32'd0);
        chk("mr_stall", {31'b0, w_stall}, 32'd0);

        // Zero drain window: handshake returns straight to RUN.
        wb_branch(32'h7000, 1'b0, 1'b1);
        tick();
        wb_idle();
        chk("z_valid1", {31'b0, w_valid0}, 32'd1);
        chk("z_eip",    w_eip0, 32'h7000);
        fe_redirect_ready = 1'b1;
        tick();
        fe_redirect_ready = 1'b0;
        chk("z_valid0", {31'b0, w_valid0}, 32'd0);
        chk("z_flush0", {31'b0, w_flush0}, 32'd0);
        chk("z_stall0", {31'b0, w_stall0}, 32'd0);
        chk("z_ref_flush", {31'b0, w_flush}, 32'd1);
        r_V_de = 1'b1; w_de_EIP_next = 32'h7004;
        tick();
        r_V_de = 1'b0;
        chk("z_adv",    w_eip0, 32'h7004);
        chk("z_ref_hold", w_eip, 32'h7000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eip_redirect_ctrl.md
Name: eip_redirect_ctrl

Overview:
Sequences all updates of the architectural EIP register and arbitrates between its three sources: exception/interrupt vectoring, taken control transfers resolved in writeback, and sequential advance from decode.
When a redirect is accepted it does three things:
- drives a valid/ready redirect handshake to fetch;
- asserts a pipeline flush;
- holds decode stalled for a programmable drain window before resuming sequential updates.

Parameters:
RESET_EIP, 32'h0000_FFF0, EIP value loaded on reset
FLUSH_CYCLES, 2, drain cycles after the fetch handshake completes (legal range 0..15)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
r_V_wb  in  1  writeback stage valid
r_wb_eip_change  in  1  writeback instruction changes EIP
r_wb_cond_met  in  1  branch condition satisfied (1 for unconditional)
r_wb_target  in  32  writeback target EIP
r_wb_pr_size_over  in  1  16-bit operand size; target masked to 16 bits
r_V_de  in  1  decode stage valid
w_not_stall_fe  in  1  front end not stalled
w_de_EIP_next  in  32  sequential next EIP from decode
exc_req  in  1  exception/interrupt request, level, held until exc_ack
exc_vector  in  32  handler EIP
fe_redirect_ready  in  1  fetch accepts redirect
r_EIP  out  32  architectural EIP
fe_redirect_valid  out  1  redirect request to fetch
fe_redirect_addr  out  32  redirect target
flush_pipe  out  1  squash younger in-flight instructions
stall_de  out  1  block decode advance
exc_ack  out  1  one-cycle acceptance pulse for exc_req

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n, sampled at the rising edge.
- Reset values:
  - r_EIP = RESET_EIP; fe_redirect_addr = RESET_EIP.
  - State = RUN; drain counter = 0.
  - fe_redirect_valid = flush_pipe = stall_de = exc_ack = 0.
- All outputs are registered.
- Taken redirect: wb_take = r_V_wb & r_wb_eip_change & r_wb_cond_met.
- Target masking: masked target = {16'h0, r_wb_target[15:0]} when r_wb_pr_size_over = 1, else r_wb_target. Exception vectors are never masked.
- States: RUN, REDIR, DRAIN.
- RUN, evaluated each cycle with fixed priority exc_req > wb_take > decode advance:
  - exc_req: next cycle r_EIP = fe_redirect_addr = exc_vector; exc_ack = 1 for exactly one cycle; fe_redirect_valid = 1, flush_pipe = 1, stall_de = 1; go to REDIR. A simultaneous wb_take is dropped.
  - wb_take: same as exc_req but the target is the masked target and there is no exc_ack.
  - r_V_de & w_not_stall_fe: r_EIP = w_de_EIP_next next cycle; stay in RUN.
  - Otherwise r_EIP holds.
- REDIR:
  - fe_redirect_valid stays 1, and fe_redirect_addr is stable until the handshake completes.
  - flush_pipe = 1, stall_de = 1.
  - wb_take and decode advance are ignored, since they come from squashed wrong-path instructions.
  - exc_req is not accepted; it stays pending until RUN.
  - Handshake completes when fe_redirect_valid & fe_redirect_ready:
    - FLUSH_CYCLES = 0: next state RUN; fe_redirect_valid, flush_pipe and stall_de all drop.
    - Otherwise: next state DRAIN, counter loaded with FLUSH_CYCLES; fe_redirect_valid drops, flush_pipe and stall_de stay 1.
- DRAIN:
  - The counter decrements once per cycle.
  - When the counter is 1, the next state is RUN, and flush_pipe and stall_de drop.
  - The drain therefore lasts exactly FLUSH_CYCLES cycles.
  - wb_take and decode advance are ignored; exc_req stays pending.
- Back-to-back redirects: an exc_req pending at DRAIN exit is accepted in the first RUN cycle, i.e. exc_ack is asserted in the second cycle after the last drain cycle.
- Reset mid-redirect: a synchronous reset in REDIR or DRAIN abandons the handshake; the next cycle shows reset values. Fetch must treat deasserted valid as cancellation.
- r_EIP changes only on the accept edge or a RUN decode advance, never during REDIR or DRAIN.
- Combinational path from fe_redirect_ready is limited to the state and counter next-state logic; no outputs depend on it combinationally.

Test Plan:
- Reset, then decode advances with w_de_EIP_next = 0x1000, 0x1003, 0x1007 on consecutive cycles with w_not_stall_fe = 1 -> r_EIP = 0x0000_FFF0 first, then tracks each value one cycle later; no flush.
- Taken branch with r_wb_target = 0x1234_5678 and r_wb_pr_size_over = 1; fe_redirect_ready held low for 3 cycles -> r_EIP = fe_redirect_addr = 0x0000_5678; fe_redirect_valid high for 4 cycles; then flush_pipe and stall_de stay high 2 more cycles; then RUN.
- Same cycle: exc_req with exc_vector = 0x8000, plus a wb_take to 0x2000 -> redirect to 0x8000; exc_ack is a single pulse; the 0x2000 target never appears.
- In DRAIN, assert wb_take to 0x3000, a decode advance, and exc_req with vector 0x9000 -> first two ignored, r_EIP unchanged; exc_ack and redirect to 0x9000 follow DRAIN exit.
- Branch whose condition is not met (r_wb_cond_met = 0) while decode is valid -> sequential update only; fe_redirect_valid stays 0.
- rst_n low during REDIR with fe_redirect_ready = 0 -> next cycle all outputs at reset values, r_EIP = 0x0000_FFF0; with FLUSH_CYCLES = 0, handshake completion returns to RUN with no drain.
